// File: rtl/tx_frame_buffer.sv
// tx_frame_buffer: store-and-forward byte frame buffer that pads runts, drops oversize frames and exposes only committed frames
module tx_frame_buffer #(
  parameter int ADDR_W  = 11,
  parameter int LEN_AW  = 3,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic              next_byte,
  output logic [7:0]        tx_data,
  output logic [15:0]       frm_len,
  output logic              empty_buff,
  output logic [LEN_AW:0]   frames_queued,
  output logic              frame_dropped
);
  typedef enum logic [1:0] {RECV, PAD, COMMIT, DROP} state_t;
  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  state_t state, state_nx;
  logic [7:0] mem [2**ADDR_W];
  logic [15:0] len_mem [2**LEN_AW];
  logic [ADDR_W:0] wr_ptr, cm_ptr, rd_ptr, used;
  logic [15:0] cur_len, cur_inc, rd_cnt;
  logic [LEN_AW:0] lf_wr, lf_rd;
  logic full, wr_en, push, drop, rd_en, rd_last;
  assign used          = wr_ptr - rd_ptr;
  assign full          = used == {1'b1, {ADDR_W{1'b0}}};
  assign cur_inc       = cur_len + 16'd1;
  assign frames_queued = lf_wr - lf_rd;
  assign empty_buff    = frames_queued == '0;
  assign frm_len       = empty_buff ? '0 : len_mem[lf_rd[LEN_AW-1:0]];
  assign rd_en         = next_byte && !empty_buff;
  assign rd_last       = rd_en && rd_cnt == frm_len - 16'd1;
  always_comb begin
    state_nx = state;
    wr_ready = 1'b0;
    wr_en    = 1'b0;
    push     = 1'b0;
    drop     = 1'b0;
    case (state)
      RECV: begin
        wr_ready = rst && !full && !frames_queued[LEN_AW];
        wr_en    = wr_valid && rst && !full && !frames_queued[LEN_AW];
        if (wr_en && wr_last) state_nx = (cur_inc < MIN_L) ? PAD : COMMIT;
        else if (wr_en && cur_inc == MAX_L) state_nx = DROP;
      end
      PAD: begin
        wr_en = !full;
        if (!full && cur_inc >= MIN_L) state_nx = COMMIT;
      end
      COMMIT: begin
        push     = 1'b1;
        state_nx = RECV;
      end
      default: begin
        wr_ready = rst;
        drop     = wr_valid && rst && wr_last;
        if (drop) state_nx = RECV;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= (state == PAD) ? 8'h00 : wr_data;
    if (push) len_mem[lf_wr[LEN_AW-1:0]] <= cur_len;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RECV;
      wr_ptr        <= '0;
      cm_ptr        <= '0;
      rd_ptr        <= '0;
      cur_len       <= '0;
      rd_cnt        <= '0;
      lf_wr         <= '0;
      lf_rd         <= '0;
      tx_data       <= '0;
      frame_dropped <= 1'b0;
    end else begin
      state         <= state_nx;
      wr_ptr        <= drop ? cm_ptr : wr_ptr + (ADDR_W+1)'(wr_en);
      cm_ptr        <= push ? wr_ptr : cm_ptr;
      cur_len       <= (push || drop) ? '0 : wr_en ? cur_inc : cur_len;
      lf_wr         <= lf_wr + (LEN_AW+1)'(push);
      lf_rd         <= lf_rd + (LEN_AW+1)'(rd_last);
      rd_ptr        <= rd_ptr + (ADDR_W+1)'(rd_en);
      rd_cnt        <= rd_last ? '0 : rd_cnt + 16'(rd_en);
      tx_data       <= rd_en ? mem[rd_ptr[ADDR_W-1:0]] : tx_data;
      frame_dropped <= drop;
    end
  end
endmodule

// File: tb/tb_tx_frame_buffer.sv
// tb_tx_frame_buffer: table-driven and scoreboard bench for tx_frame_buffer
module tb_tx_frame_buffer;
  typedef struct {int len; int seed; int exp_len; int exp_lo;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] wr_data = '0;
  logic wr_valid = 1'b0, wr_last = 1'b0, next_byte = 1'b0;
  logic wr_ready, empty_buff, frame_dropped;
  logic [7:0] tx_data;
  logic [15:0] frm_len;
  logic [3:0] frames_queued;
  int nvec = 0, nerr = 0, drops = 0;
  logic [7:0] sb[$];
  int lq[$];
  vec_t tbl[7];
  tx_frame_buffer dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last),
    .wr_ready(wr_ready), .next_byte(next_byte), .tx_data(tx_data), .frm_len(frm_len),
    .empty_buff(empty_buff), .frames_queued(frames_queued), .frame_dropped(frame_dropped)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_dropped) drops++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    wr_last  = last;
    while (!wr_ready && n < 5000) begin
      step;
      n++;
    end
    if (!wr_ready) begin
      nvec++;
      nerr++;
      $display("FAIL wr_ready_timeout: got 0 expected 1 at %0t", $time);
    end else step;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask
  task automatic send_frame(input int len, input int seed, output int lo);
    logic [7:0] b;
    bit drop;
    drop = len > 1518;
    for (int i = 0; i < len; i++) begin
      b = 8'(seed + i);
      if (!drop) sb.push_back(b);
      send_byte(b, i == len - 1);
    end
    if (!drop) begin
      for (int i = len; i < 64; i++) sb.push_back(8'h00);
      lq.push_back(len < 64 ? 64 : len);
    end
    chk("frame_dropped_pulse", frame_dropped, drop);
    lo = 0;
    while (!wr_ready && frames_queued != 4'd8 && lo < 100) begin
      step;
      lo++;
    end
    if (drop) begin
      step;
      chk("frame_dropped_end", frame_dropped, 0);
    end
  endtask
  task automatic read_frame(input int done);
    int len, n = 0;
    while (empty_buff && n < 5000) begin
      step;
      n++;
    end
    if (empty_buff || lq.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL read_timeout: empty_buff %0d queued_lengths %0d", empty_buff, lq.size());
      return;
    end
    len = lq.pop_front();
    chk("frm_len_head", frm_len, len);
    next_byte = 1'b1;
    for (int i = done; i < len; i++) begin
      step;
      chk("tx_data", tx_data, sb.pop_front());
    end
    next_byte = 1'b0;
  endtask
  initial begin
    int lo, d0;
    logic [7:0] b;
    tbl[0] = '{100, 0, 100, 1};
    tbl[1] = '{10, 64, 64, 55};
    tbl[2] = '{63, 16, 64, 2};
    tbl[3] = '{1, 7, 64, 64};
    tbl[4] = '{64, 32, 64, 1};
    tbl[5] = '{1518, 51, 1518, 1};
    tbl[6] = '{1519, 9, 0, 0};
    repeat (3) step;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_frm_len", frm_len, 0);
    chk("rst_empty", empty_buff, 1);
    chk("rst_queued", frames_queued, 0);
    chk("rst_dropped", frame_dropped, 0);
    chk("rst_wr_ready", wr_ready, 0);
    rst = 1'b1;
    step;
    chk("idle_wr_ready", wr_ready, 1);
    for (int v = 0; v < 7; v++) begin
      send_frame(tbl[v].len, tbl[v].seed, lo);
      chk("ready_low_cycles", lo, tbl[v].exp_lo);
      chk("queued_after_frame", frames_queued, tbl[v].exp_len != 0);
      chk("frm_len_after_frame", frm_len, tbl[v].exp_len);
      if (tbl[v].exp_len != 0) read_frame(0);
      chk("empty_after_read", empty_buff, 1);
      chk("frm_len_after_read", frm_len, 0);
      if (v == 0) begin
        next_byte = 1'b1;
        step;
        step;
        next_byte = 1'b0;
        chk("empty_pop_hold", tx_data, 8'(tbl[0].seed + tbl[0].len - 1));
      end
    end
    send_frame(64, 8'h80, lo);
    d0 = drops;
    send_frame(1600, 3, lo);
    step;
    chk("drop_pulse_count", drops - d0, 1);
    chk("drop_keeps_queue", frames_queued, 1);
    read_frame(0);
    send_frame(64, 8'hA0, lo);
    send_frame(80, 8'hC0, lo);
    fork
      send_frame(70, 8'h11, lo);
      begin
        read_frame(0);
        read_frame(0);
      end
    join
    read_frame(0);
    chk("wrap_drained", empty_buff, 1);
    for (int k = 0; k < 8; k++) send_frame(64, k * 8, lo);
    chk("eight_queued", frames_queued, 8);
    chk("eight_wr_ready", wr_ready, 0);
    step;
    chk("eight_wr_ready_hold", wr_ready, 0);
    read_frame(0);
    chk("seven_queued", frames_queued, 7);
    step;
    chk("seven_wr_ready", wr_ready, 1);
    for (int k = 1; k < 8; k++) read_frame(0);
    send_frame(64, 8'h55, lo);
    for (int i = 0; i < 30; i++) send_byte(8'(i + 1), 1'b0);
    next_byte = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step;
      chk("pre_reset_tx", tx_data, sb.pop_front());
    end
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_frm_len", frm_len, 0);
    chk("mid_rst_empty", empty_buff, 1);
    chk("mid_rst_queued", frames_queued, 0);
    chk("mid_rst_dropped", frame_dropped, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    next_byte = 1'b0;
    sb.delete();
    lq.delete();
    step;
    step;
    rst = 1'b1;
    step;
    chk("post_rst_empty", empty_buff, 1);
    chk("post_rst_wr_ptr", dut.wr_ptr, 0);
    chk("post_rst_rd_ptr", dut.rd_ptr, 0);
    send_frame(70, 8'h21, lo);
    read_frame(0);
    send_frame(1518, 8'h3C, lo);
    for (int i = 0; i < 530; i++) begin
      b = 8'(8'h5A + i);
      sb.push_back(b);
      send_byte(b, 1'b0);
    end
    chk("full_wr_ready", wr_ready, 0);
    step;
    step;
    chk("full_wr_ready_hold", wr_ready, 0);
    next_byte = 1'b1;
    step;
    next_byte = 1'b0;
    chk("full_first_pop", tx_data, sb.pop_front());
    chk("full_freed_ready", wr_ready, 1);
    b = 8'(8'h5A + 530);
    sb.push_back(b);
    lq.push_back(531);
    send_byte(b, 1'b1);
    step;
    chk("full_two_queued", frames_queued, 2);
    read_frame(1);
    read_frame(0);
    chk("final_empty", empty_buff, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
  initial begin
    #3000000;
    nvec++;
    nerr++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
